// File: rtl/aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_round_ctrl
//
// Iterative AES decryption sequencer. Owns the 128-bit working state and the
// round counter, applies the initial AddRoundKey on block acceptance, then
// steps an external combinational inverse-round datapath once per cycle
// (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) until round 0, which
// skips InvMixColumns. The finished block is held on plainOut until the sink
// takes it; a new block may be accepted in that same cycle.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   in_valid       cipherIn holds a valid block
//   in_ready       block accepted when in_valid && in_ready
//   cipherIn       ciphertext block, byte 0 = bits [0:7]
//   round_key_idx  index of the round key needed this cycle
//   round_key      round key for round_key_idx, valid in the same cycle
//   dp_state       state presented to the inverse-round datapath
//   dp_last        final round: datapath bypasses InvMixColumns
//   dp_result      datapath result for dp_state / round_key / dp_last
//   out_valid      plainOut holds a finished block
//   out_ready      sink accepts when out_valid && out_ready
//   plainOut       plaintext block
//   busy           high while a block is being processed or awaiting pickup
//
// KIDX_W must be wide enough to hold NR (2**KIDX_W > NR).
// -----------------------------------------------------------------------------
module aes_inv_round_ctrl #(
   parameter int NR     = 10,
   parameter int KIDX_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:127]      cipherIn,
   output logic [KIDX_W-1:0] round_key_idx,
   input  logic [0:127]      round_key,
   output logic [0:127]      dp_state,
   output logic              dp_last,
   input  logic [0:127]      dp_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:127]      plainOut,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsmStateT;

   localparam logic [KIDX_W-1:0] KIDX_FIRST = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] ROUND_INIT = KIDX_W'(NR - 1);
   localparam logic [KIDX_W-1:0] ROUND_ZERO = {KIDX_W{1'b0}};
   localparam logic [KIDX_W-1:0] ROUND_ONE  = {{(KIDX_W-1){1'b0}}, 1'b1};

   fsmStateT          fsmState;
   logic [0:127]      stateReg;
   logic [KIDX_W-1:0] roundCnt;
   logic              outValidReg;
   logic              busyReg;
   logic              accept;

   // Handshake and datapath control decoded from the FSM state.
   always_comb begin
      in_ready      = 1'b0;
      round_key_idx = KIDX_FIRST;
      dp_last       = 1'b0;
      case (fsmState)
         IDLE: begin
            in_ready = 1'b1;
         end
         ROUND: begin
            round_key_idx = roundCnt;
            if (roundCnt == ROUND_ZERO) begin
               dp_last = 1'b1;
            end else begin
               dp_last = 1'b0;
            end
         end
         DONE: begin
            // The slot frees up in the same cycle the sink takes the result,
            // so a waiting block loses no cycle; key index stays at NR here.
            in_ready = out_ready;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign accept    = in_valid && in_ready;
   assign dp_state  = stateReg;
   assign plainOut  = stateReg;
   assign out_valid = outValidReg;
   assign busy      = busyReg;

   // Sequencer FSM: state register, round counter and registered status.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsmState    <= IDLE;
         stateReg    <= 128'h0;
         roundCnt    <= ROUND_ZERO;
         outValidReg <= 1'b0;
         busyReg     <= 1'b0;
      end else begin
         case (fsmState)
            IDLE: begin
               if (accept) begin
                  // Initial AddRoundKey with key NR (round_key_idx = NR in IDLE).
                  stateReg <= cipherIn ^ round_key;
                  roundCnt <= ROUND_INIT;
                  fsmState <= ROUND;
                  busyReg  <= 1'b1;
               end
            end
            ROUND: begin
               stateReg <= dp_result;
               if (roundCnt == ROUND_ZERO) begin
                  // Counter parks at zero; it is reloaded on the next accept.
                  fsmState    <= DONE;
                  outValidReg <= 1'b1;
               end else begin
                  roundCnt <= roundCnt - ROUND_ONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValidReg <= 1'b0;
                  if (in_valid) begin
                     stateReg <= cipherIn ^ round_key;
                     roundCnt <= ROUND_INIT;
                     fsmState <= ROUND;
                     busyReg  <= 1'b1;
                  end else begin
                     fsmState <= IDLE;
                     busyReg  <= 1'b0;
                  end
               end
            end
            default: begin
               fsmState    <= IDLE;
               outValidReg <= 1'b0;
               busyReg     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
module tb_aes_inv_round_ctrl;

   localparam int NR     = 10;
   localparam int KIDX_W = 4;

   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT2 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d0badc0de12345678;

   logic              clk;
   logic              reset;
   logic              inValid;
   logic              inReady;
   logic [127:0]      cipherIn;
   logic [KIDX_W-1:0] roundKeyIdx;
   logic [127:0]      roundKey;
   logic [127:0]      dpState;
   logic              dpLast;
   logic [127:0]      dpResult;
   logic              outValid;
   logic              outReady;
   logic [127:0]      plainOut;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0]   sbox    [256];
   logic [7:0]   invSbox [256];
   logic [127:0] rk      [16];

   aes_inv_round_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (inValid),
      .in_ready      (inReady),
      .cipherIn      (cipherIn),
      .round_key_idx (roundKeyIdx),
      .round_key     (roundKey),
      .dp_state      (dpState),
      .dp_last       (dpLast),
      .dp_result     (dpResult),
      .out_valid     (outValid),
      .out_ready     (outReady),
      .plainOut      (plainOut),
      .busy          (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AES reference pieces ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic buildTables();
      logic [7:0]  inv;
      logic [7:0]  s;
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x] = s;
      end
      for (int x = 0; x < 256; x++) invSbox[sbox[x]] = 8'(x);
      for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int k = 0; k < 16; k++) begin
         if (k <= NR) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
         else         rk[k] = 128'h0;
      end
   endtask

   // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last.
   function automatic logic [127:0] invRound(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   m [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int rr = 0; rr < 4; rr++)
         for (int c = 0; c < 4; c++)
            b[rr+4*c] = a[rr + 4*((c - rr + 4) % 4)];
      for (int i = 0; i < 16; i++) b[i] = invSbox[b[i]] ^ k[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
         m[4*c+0] = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
         m[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
         m[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
         m[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? b[i] : m[i];
      return r;
   endfunction

   function automatic logic [127:0] refDecrypt(input logic [127:0] c);
      logic [127:0] s;
      s = c ^ rk[NR];
      for (int r = NR - 1; r >= 1; r--) s = invRound(s, rk[r], 1'b0);
      s = invRound(s, rk[0], 1'b1);
      return s;
   endfunction

   // Key store and datapath models driving the DUT's combinational inputs.
   always_comb roundKey = rk[roundKeyIdx];
   always_comb dpResult = invRound(dpState, roundKey, dpLast);

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitValid(input int budget, output int when);
      int n;
      n = 0;
      while (outValid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      when = cyc;
      check("out_valid_timeout", 128'(outValid), 128'd1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int t1;
      int t2;
      int n;
      int pulses;

      buildTables();
      reset    = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b0;
      cipherIn = 128'h0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_out_valid", 128'(outValid), 128'd0);
      check("rst_busy",      128'(busy), 128'd0);
      check("rst_dp_last",   128'(dpLast), 128'd0);
      check("rst_key_idx",   128'(roundKeyIdx), 128'd10);
      check("rst_in_ready",  128'(inReady), 128'd1);
      check("rst_state",     plainOut, 128'h0);
      reset = 1'b0;

      // FIPS-197 C.1 with key-index trace and latency
      cipherIn = CT; inValid = 1'b1; outReady = 1'b1;
      #1;
      check("c1_accept_ready", 128'(inReady), 128'd1);
      check("c1_accept_idx",   128'(roundKeyIdx), 128'd10);
      @(negedge clk);
      inValid = 1'b0; cipherIn = 128'h0;
      for (int k = NR - 1; k >= 0; k--) begin
         check("trace_idx",       128'(roundKeyIdx), 128'(k));
         check("trace_dp_last",   128'(dpLast), 128'(k == 0));
         check("trace_out_valid", 128'(outValid), 128'd0);
         check("trace_in_ready",  128'(inReady), 128'd0);
         check("trace_busy",      128'(busy), 128'd1);
         @(negedge clk);
      end
      check("c1_latency_valid", 128'(outValid), 128'd1);
      check("c1_plain",         plainOut, PT);
      check("c1_done_busy",     128'(busy), 128'd1);
      @(negedge clk);
      check("c1_idle_valid", 128'(outValid), 128'd0);
      check("c1_idle_busy",  128'(busy), 128'd0);
      check("c1_idle_ready", 128'(inReady), 128'd1);

      // Backpressure: sink stalls 5 cycles while a new block is offered
      outReady = 1'b0; cipherIn = CT; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      waitValid(20, t1);
      for (int i = 0; i < 5; i++) begin
         cipherIn = JUNK; inValid = 1'b1;
         #1;
         check("bp_in_ready", 128'(inReady), 128'd0);
         @(negedge clk);
         check("bp_out_valid", 128'(outValid), 128'd1);
         check("bp_plain",     plainOut, PT);
         check("bp_busy",      128'(busy), 128'd1);
      end
      inValid = 1'b0; outReady = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 128'(outValid), 128'd0);
      check("bp_release_ready", 128'(inReady), 128'd1);
      check("bp_release_busy",  128'(busy), 128'd0);
      repeat (3) @(negedge clk);
      check("bp_no_new_block", 128'(busy), 128'd0);

      // Back-to-back: second block accepted in the DONE cycle of the first
      cipherIn = CT; inValid = 1'b1; outReady = 1'b1;
      @(negedge clk);
      waitValid(20, t1);
      check("b2b_first_plain", plainOut, PT);
      check("b2b_done_ready",  128'(inReady), 128'd1);
      check("b2b_done_idx",    128'(roundKeyIdx), 128'd10);
      @(negedge clk);
      check("b2b_second_taken", 128'(roundKeyIdx), 128'd9);
      check("b2b_gap_valid",    128'(outValid), 128'd0);
      check("b2b_gap_busy",     128'(busy), 128'd1);
      inValid = 1'b0;
      waitValid(20, t2);
      check("b2b_spacing",      128'(t2 - t1), 128'd11);
      check("b2b_second_plain", plainOut, PT);
      @(negedge clk);
      check("b2b_idle_busy", 128'(busy), 128'd0);

      // Reset in round 5 discards the block
      cipherIn = CT; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      n = 0;
      while (roundKeyIdx !== 4'd5 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach_round5", 128'(roundKeyIdx), 128'd5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_valid", 128'(outValid), 128'd0);
      check("mid_rst_busy",  128'(busy), 128'd0);
      check("mid_rst_ready", 128'(inReady), 128'd1);
      check("mid_rst_idx",   128'(roundKeyIdx), 128'd10);
      check("mid_rst_state", plainOut, 128'h0);
      pulses = 0;
      repeat (14) begin
         @(negedge clk);
         if (outValid === 1'b1) pulses++;
      end
      check("mid_rst_no_output", 128'(pulses), 128'd0);
      cipherIn = CT2; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      waitValid(20, t1);
      check("mid_rst_next_plain", plainOut, refDecrypt(CT2));
      @(negedge clk);
      check("mid_rst_next_idle", 128'(outValid), 128'd0);

      // in_valid pulsed while busy is ignored
      cipherIn = PT; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      repeat (3) @(negedge clk);
      cipherIn = JUNK; inValid = 1'b1;
      #1;
      check("pulse_in_ready", 128'(inReady), 128'd0);
      @(negedge clk);
      inValid = 1'b0; cipherIn = 128'h0;
      waitValid(20, t1);
      check("pulse_plain", plainOut, refDecrypt(PT));
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (outValid === 1'b1) pulses++;
      end
      check("pulse_no_extra_output", 128'(pulses), 128'd0);
      check("pulse_final_busy",      128'(busy), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
